// File: rtl/frame_pkg.sv
// Shared types and helpers for the frame pixel engine.
package frame_pkg;

  typedef enum logic [1:0] {
    ModePass   = 2'd0,
    ModeThresh = 2'd1,
    ModeInvert = 2'd2,
    ModeWindow = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Bits needed to index n items; never less than one.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tag_delay.sv
// Fixed-depth delay line that carries a valid bit and a tag alongside the read data.
module tag_delay #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic [Depth-1:0] valid_q;
  logic [Width-1:0] data_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/frame_pixel_engine.sv
// Streams one frame from a read buffer through a per-pixel operation into a write buffer.
module frame_pixel_engine
  import frame_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned DIN_W  = 8,
  parameter int unsigned DOUT_W = 4,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WIN_W  = 320,
  parameter int unsigned WIN_H  = 240,
  localparam int unsigned ADDR_W = addr_width(WIDTH * HEIGHT)
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [1:0]        mode,
  input  logic [DIN_W-1:0]  threshold,
  input  logic [DIN_W-1:0]  din,
  output logic [ADDR_W-1:0] addr_rd,
  output logic [ADDR_W-1:0] addr_wr,
  output logic [DOUT_W-1:0] dout,
  output logic              we,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned NPIX  = WIDTH * HEIGHT;
  localparam int unsigned X_W   = addr_width(WIDTH);
  localparam int unsigned Y_W   = addr_width(HEIGHT);
  localparam int unsigned TAG_W = ADDR_W + X_W + Y_W;
  localparam int unsigned X_LO  = (WIDTH - WIN_W) / 2;
  localparam int unsigned X_HI  = (WIDTH + WIN_W) / 2;
  localparam int unsigned Y_LO  = (HEIGHT - WIN_H) / 2;
  localparam int unsigned Y_HI  = (HEIGHT + WIN_H) / 2;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NPIX - 1);
  localparam logic [X_W-1:0]    LastX    = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]    LastY    = Y_W'(HEIGHT - 1);
  localparam logic [2:0]        DrainEnd = 3'(RD_LAT + 1);

  state_e             state_q, state_d;
  mode_e              mode_q;
  logic [DIN_W-1:0]   thresh_q;
  logic [ADDR_W-1:0]  addr_rd_q, addr_wr_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [2:0]         drain_q;
  logic [DOUT_W-1:0]  dout_q;
  logic               we_q, busy_q, done_q;
  logic               frame_start;

  logic               tag_valid;
  logic [TAG_W-1:0]   tag_data;
  logic [ADDR_W-1:0]  tag_addr;
  logic [X_W-1:0]     tag_x;
  logic [Y_W-1:0]     tag_y;
  logic [DOUT_W-1:0]  pass_px, pix;
  logic               in_win;

  tag_delay #(
    .Depth(RD_LAT),
    .Width(TAG_W)
  ) u_tag_delay (
    .clk_i  (clk25),
    .rst_i  (rst),
    .valid_i(state_q == StRun),
    .data_i ({addr_rd_q, x_q, y_q}),
    .valid_o(tag_valid),
    .data_o (tag_data)
  );

  assign {tag_addr, tag_x, tag_y} = tag_data;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start || cont) state_d = StRun;
      StRun:   if (addr_rd_q == LastAddr) state_d = StDrain;
      // Hold DRAIN one cycle past the last write so DONE lands on the second idle cycle.
      StDrain: if (drain_q == DrainEnd) state_d = StDone;
      StDone:  state_d = (start || cont) ? StRun : StIdle;
    endcase
  end

  assign frame_start = (state_d == StRun) && (state_q != StRun);

  assign pass_px = din[DIN_W-1 -: DOUT_W];
  assign in_win  = (32'(tag_x) >= X_LO) && (32'(tag_x) < X_HI) &&
                   (32'(tag_y) >= Y_LO) && (32'(tag_y) < Y_HI);

  always_comb begin
    pix = '0;
    unique case (mode_q)
      ModePass:   pix = pass_px;
      ModeThresh: pix = (din >= thresh_q) ? '1 : '0;
      ModeInvert: pix = ~pass_px;
      ModeWindow: pix = in_win ? pass_px : '0;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q   <= StIdle;
      mode_q    <= ModePass;
      thresh_q  <= '0;
      addr_rd_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      drain_q   <= '0;
      we_q      <= 1'b0;
      addr_wr_q <= '0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == StRun) || (state_d == StDrain);
      done_q  <= (state_d == StDone);

      if (frame_start) begin
        mode_q    <= mode_e'(mode);
        thresh_q  <= threshold;
        addr_rd_q <= '0;
        x_q       <= '0;
        y_q       <= '0;
      end else if (state_q == StRun) begin
        if (state_d == StRun) addr_rd_q <= addr_rd_q + ADDR_W'(1);
        if (x_q == LastX) begin
          x_q <= '0;
          y_q <= (y_q == LastY) ? '0 : y_q + Y_W'(1);
        end else begin
          x_q <= x_q + X_W'(1);
        end
      end

      drain_q <= (state_q == StDrain) ? drain_q + 3'd1 : 3'd0;

      we_q <= tag_valid;
      if (tag_valid) begin
        addr_wr_q <= tag_addr;
        dout_q    <= pix;
      end
    end
  end

  assign addr_rd    = addr_rd_q;
  assign addr_wr    = addr_wr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
